// File: rtl/gba_cart_arbiter.sv
// Shares one single-port memory between GBA cart reads (always first) and a host port.
// Define GBA_ARB_PREFETCH_EN to add a one-word read-ahead buffer on the GBA side.
module gba_cart_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk100,
    input  logic          rst,
    input  logic          cs_fall,
    input  logic          rd_fall,
    input  logic          rd_rise,
    input  logic [15:0]   addr_in,
    output logic [DW-1:0] gba_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GBA_RD  = 3'd1,
        GBA_CAP = 3'd2,
        HOST_WR = 3'd3,
        HOST_RD = 3'd4
`ifdef GBA_ARB_PREFETCH_EN
        ,
        PF_RD   = 3'd5,
        PF_CAP  = 3'd6
`endif
    } state_t;

    state_t        state, state_next;
    state_t        pick_gba, pick_all;
    logic [AW-1:0] gaddr;
    logic          gba_pend;
    logic          gba_new;     // rd_fall that needs a memory read
    logic          gba_req;
    logic          hrd_cap;     // second cycle of HOST_RD
    logic [DW-1:0] rdata_q;
    logic          unused_addr;

    assign unused_addr = ^addr_in[15:AW];

`ifdef GBA_ARB_PREFETCH_EN
    logic [DW-1:0] pf_data;
    logic [AW-1:0] pf_addr, pf_iaddr;
    logic          pf_valid, pf_want;
    logic          pf_hit, pf_hit_live;

    // A fill still in its capture cycle can serve the GBA straight from mem_rdata.
    assign pf_hit_live = (state == PF_CAP) && (pf_iaddr == gaddr);
    assign pf_hit      = rd_fall && ((pf_valid && (pf_addr == gaddr)) || pf_hit_live);
    assign gba_new     = rd_fall && !pf_hit;
`else
    assign gba_new     = rd_fall;
`endif

    assign gba_req = gba_pend || gba_new;

    // GBA-side choice (never host); terminal host states use this so a held
    // host_req is not granted twice in its own ack cycle.
    always_comb begin
        pick_gba = IDLE;
        if (gba_req) begin
            pick_gba = GBA_RD;
        end
`ifdef GBA_ARB_PREFETCH_EN
        else if (pf_want) begin
            pick_gba = PF_RD;
        end
`endif
    end

    always_comb begin
        pick_all = pick_gba;
        if (pick_gba == IDLE && host_req) begin
            pick_all = host_we ? HOST_WR : HOST_RD;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Terminal states re-arbitrate directly, so returning through IDLE costs no
    // cycle and the GBA worst case stays at 4 cycles behind a host read.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        host_ack   = 1'b0;
        host_rdata = rdata_q;
        case (state)
            IDLE: state_next = pick_all;
            GBA_RD: begin
                mem_en     = 1'b1;
                mem_addr   = gaddr;
                state_next = GBA_CAP;
            end
            GBA_CAP: state_next = pick_all;
            HOST_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = host_addr;
                mem_wdata  = host_wdata;
                host_ack   = 1'b1;
                state_next = pick_gba;
            end
            HOST_RD: begin
                if (!hrd_cap) begin
                    mem_en   = 1'b1;
                    mem_addr = host_addr;
                end else begin
                    // Bypass so read data is valid in the same cycle as host_ack.
                    host_ack   = 1'b1;
                    host_rdata = mem_rdata;
                    state_next = pick_gba;
                end
            end
`ifdef GBA_ARB_PREFETCH_EN
            PF_RD: begin
                mem_en     = 1'b1;
                mem_addr   = gaddr;
                state_next = PF_CAP;
            end
            PF_CAP: state_next = pick_all;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            gaddr    <= '0;
            gba_pend <= 1'b0;
            gba_data <= '0;
            rdata_q  <= '0;
            hrd_cap  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together.
            if (rd_rise) begin
                gaddr <= gaddr + AW'(1);
            end else if (cs_fall) begin
                gaddr <= addr_in[AW-1:0];
            end

            if (gba_new) begin
                gba_pend <= 1'b1;
            end else if (state == GBA_RD) begin
                gba_pend <= 1'b0;
            end

            hrd_cap <= (state == HOST_RD) && !hrd_cap;

            if (hrd_cap) begin
                rdata_q <= mem_rdata;
            end

            if (state == GBA_CAP) begin
                gba_data <= mem_rdata;
            end
`ifdef GBA_ARB_PREFETCH_EN
            if (pf_hit) begin
                gba_data <= pf_hit_live ? mem_rdata : pf_data;
            end
`endif
        end
    end

`ifdef GBA_ARB_PREFETCH_EN
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            pf_data  <= '0;
            pf_addr  <= '0;
            pf_iaddr <= '0;
            pf_valid <= 1'b0;
            pf_want  <= 1'b0;
        end else begin
            if (rd_rise) begin
                pf_want <= 1'b1;
            end else if (state == PF_RD || state == GBA_RD) begin
                pf_want <= 1'b0;
            end

            if (state == PF_RD) begin
                pf_iaddr <= gaddr;
            end

            if (state == PF_CAP) begin
                pf_data <= mem_rdata;
                pf_addr <= pf_iaddr;
            end

            if (cs_fall || (state == HOST_WR && host_addr == pf_addr)) begin
                pf_valid <= 1'b0;
            end else if (state == PF_CAP) begin
                pf_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gba_cart_arbiter.sv
// Directed bench for gba_cart_arbiter with a behavioural 1-cycle-latency memory.
// Prefetch-hit vectors run only when GBA_ARB_PREFETCH_EN is defined.
module tb_gba_cart_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk100 = 1'b0;
    logic          rst;
    logic          cs_fall, rd_fall, rd_rise;
    logic [15:0]   addr_in;
    logic [DW-1:0] gba_data;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    gba_cart_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk100     (clk100),
        .rst        (rst),
        .cs_fall    (cs_fall),
        .rd_fall    (rd_fall),
        .rd_rise    (rd_rise),
        .addr_in    (addr_in),
        .gba_data   (gba_data),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk100);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_gba(input string tag, input logic [DW-1:0] exp, input int budget);
        int n = 0;
        while (gba_data !== exp && n < budget) begin
            cyc();
            n++;
        end
        check(tag, 64'(gba_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h1000 + 16'(i);
        mem[9'h010] = 16'hBEEF;
        rst = 1'b1;
        cs_fall = 1'b0; rd_fall = 1'b0; rd_rise = 1'b0; addr_in = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        idle(2);
        check("rst_outs", {gba_data, host_ack, host_rdata}, 64'd0);
        check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;
        cyc();
        check("rst_gaddr", 64'(dut.gaddr), 64'd0);

        // Load 0x010, read it back.
        addr_in = 16'h0010; cs_fall = 1'b1; cyc(); cs_fall = 1'b0;
        rd_fall = 1'b1; cyc(); rd_fall = 1'b0;
        check("t1_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 9'h010});
        cyc();
        check("t1_cap_quiet", 64'(mem_en), 64'd0);
        cyc();
        check("t1_gba_data", 64'(gba_data), 64'hBEEF);

        // Address wrap 0x1FE -> 0x1FF -> 0x000 -> 0x001.
        addr_in = 16'h01FE; cs_fall = 1'b1; cyc(); cs_fall = 1'b0;
        check("t2_load", 64'(dut.gaddr), 64'h1FE);
        rd_rise = 1'b1; cyc(); rd_rise = 1'b0;
        check("t2_gaddr_1ff", 64'(dut.gaddr), 64'h1FF);
        rd_rise = 1'b1; cyc(); rd_rise = 1'b0;
        check("t2_gaddr_000", 64'(dut.gaddr), 64'h000);
        rd_rise = 1'b1; cyc(); rd_rise = 1'b0;
        check("t2_gaddr_001", 64'(dut.gaddr), 64'h001);
        rd_fall = 1'b1; cyc(); rd_fall = 1'b0;
        check("t2_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 9'h001});
        wait_gba("t2_gba_data", 16'h1001, 4);
        idle(6);

        // Host write collides with rd_fall: GBA first, ack two cycles after the issue.
        host_req = 1'b1; host_we = 1'b1; host_addr = 9'h005; host_wdata = 16'h1234;
        rd_fall = 1'b1; cyc(); rd_fall = 1'b0;
        check("t3_gba_first", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 9'h001});
        check("t3_no_ack_issue", 64'(host_ack), 64'd0);
        cyc();
        check("t3_no_ack_cap", 64'(host_ack), 64'd0);
        cyc();
        check("t3_ack", 64'(host_ack), 64'd1);
        check("t3_wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 9'h005, 16'h1234});
        host_req = 1'b0; host_we = 1'b0;
        cyc();
        check("t3_ack_pulse", 64'(host_ack), 64'd0);
        check("t3_idle_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);

        // Host read back of 0x005.
        host_req = 1'b1; host_we = 1'b0; host_addr = 9'h005; cyc();
        check("t3_rd_issue", {host_ack, mem_en, mem_we, mem_addr}, {1'b0, 1'b1, 1'b0, 9'h005});
        cyc();
        check("t3_rd_ack", 64'(host_ack), 64'd1);
        check("t3_rdata", 64'(host_rdata), 64'h1234);
        host_req = 1'b0;
        cyc();
        check("t3_rdata_hold", {host_ack, host_rdata}, {1'b0, 16'h1234});
        idle(2);

        // rd_rise beats cs_fall in the same cycle.
        addr_in = 16'h0020; cs_fall = 1'b1; cyc(); cs_fall = 1'b0;
        addr_in = 16'h0040; cs_fall = 1'b1; rd_rise = 1'b1; cyc();
        cs_fall = 1'b0; rd_rise = 1'b0;
        check("t4_gaddr", 64'(dut.gaddr), 64'h021);
        rd_fall = 1'b1; cyc(); rd_fall = 1'b0;
        wait_gba("t4_gba_data", 16'h1021, 4);
        idle(6);

        // Reset in the issue cycle of a host read.
        host_req = 1'b1; host_we = 1'b0; host_addr = 9'h007; cyc();
        check("t5_rd_issue", 64'(mem_en), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_outs", {gba_data, host_ack, host_rdata}, 64'd0);
        check("t5_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        host_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("t5_rst_hold", {host_ack, mem_en, gba_data, host_rdata}, 64'd0);
        end
        rst = 1'b0;
        cyc();
        check("t5_post_quiet", {host_ack, mem_en}, 64'd0);
        rd_fall = 1'b1; cyc(); rd_fall = 1'b0;
        check("t5_idle_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 9'h000});
        wait_gba("t5_gba_data", 16'h1000, 4);
        idle(4);

`ifdef GBA_ARB_PREFETCH_EN
        // Prefetch hit: gba_data served without a memory access.
        addr_in = 16'h0030; cs_fall = 1'b1; cyc(); cs_fall = 1'b0;
        rd_rise = 1'b1; cyc(); rd_rise = 1'b0;
        check("t6_gaddr", 64'(dut.gaddr), 64'h031);
        idle(3);
        rd_fall = 1'b1; cyc(); rd_fall = 1'b0;
        check("t6_hit_data", 64'(gba_data), 64'h1031);
        check("t6_no_mem", 64'(mem_en), 64'd0);
        idle(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
